// File: rtl/renkon_if.sv
// Host bus of the renkon convolution accelerator: memory load/readback plus run control.
// The host drives the master side; the accelerator owns the slave side.
interface renkon_if #(
   parameter int CORE    = 8,
   parameter int DWIDTH  = 16,
   parameter int IMGSIZE = 12,
   parameter int NETSIZE = 14,
   parameter int LWIDTH  = 10,
   parameter int CORELOG = $clog2(CORE)
);
   logic                      req;
   logic                      ack;
   logic                      img_we;
   logic [IMGSIZE-1:0]        input_addr;
   logic [IMGSIZE-1:0]        output_addr;
   logic signed [DWIDTH-1:0]  write_img;
   logic [CORELOG:0]          net_we;
   logic [NETSIZE-1:0]        net_addr;
   logic signed [DWIDTH-1:0]  write_net;
   logic [LWIDTH-1:0]         total_out;
   logic [LWIDTH-1:0]         total_in;
   logic [LWIDTH-1:0]         img_size;
   logic [LWIDTH-1:0]         fil_size;
   logic [LWIDTH-1:0]         pool_size;
   logic signed [DWIDTH-1:0]  read_img;

   modport master (
      output req, img_we, input_addr, output_addr, write_img, net_we, net_addr, write_net,
             total_out, total_in, img_size, fil_size, pool_size,
      input  ack, read_img
   );

   modport slave (
      input  req, img_we, input_addr, output_addr, write_img, net_we, net_addr, write_net,
             total_out, total_in, img_size, fil_size, pool_size,
      output ack, read_img
   );
endinterface

// File: rtl/renkon.sv
// CNN convolution layer engine: valid conv + bias + ReLU + max-pool, CORE output channels in parallel.
// One MAC per cycle per core; pooled results of each window are written back serially.
module renkon #(
   parameter int CORE    = 8,
   parameter int DWIDTH  = 16,
   parameter int QBITS   = 8,
   parameter int IMGSIZE = 12,
   parameter int NETSIZE = 14,
   parameter int LWIDTH  = 10,
   localparam int CORELOG = $clog2(CORE)
) (
   input logic     clk,
   input logic     xrst,
   renkon_if.slave host
);
   localparam int ACCW = 2*DWIDTH + 8;
   localparam int NWW  = CORELOG + 1;
   localparam logic [LWIDTH-1:0]  ONE  = LWIDTH'(1);
   localparam logic [CORELOG-1:0] WONE = CORELOG'(1);

   typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_e;

   state_e state_q, state_d;

   logic [IMGSIZE-1:0] inBase_q, outBase_q;
   logic [NETSIZE-1:0] netBase_q;
   logic [LWIDTH-1:0]  nOut_q, nIn_q, iSz_q, fSz_q, pSz_q, oSz_q;

   logic [LWIDTH-1:0]  g_q, py_q, px_q, wy_q, wx_q, k_q, fy_q, fx_q;
   logic [LWIDTH-1:0]  g_d, py_d, px_d, wy_d, wx_d, k_d, fy_d, fx_d;
   logic [CORELOG-1:0] wc_q, wc_d;

   logic signed [ACCW-1:0]   acc_q [CORE];
   logic signed [ACCW-1:0]   acc_d [CORE];
   logic signed [DWIDTH-1:0] mx_q  [CORE];
   logic signed [DWIDTH-1:0] mx_d  [CORE];

   logic                     ack_q, ack_d;
   logic signed [DWIDTH-1:0] readImg_q;

   logic signed [DWIDTH-1:0] imgMem [2**IMGSIZE];
   logic signed [DWIDTH-1:0] netMem [CORE][2**NETSIZE];

   logic                     start;
   logic [31:0]              iSq, fSq, blk, gBase, rowY, colX, chan;
   logic [NETSIZE-1:0]       wAddr, bAddr;
   logic [IMGSIZE-1:0]       pAddr, oAddr;
   logic                     chanValid;
   logic signed [DWIDTH-1:0] pix;
   logic signed [DWIDTH-1:0]   wgt    [CORE];
   logic signed [DWIDTH-1:0]   bias   [CORE];
   logic signed [2*DWIDTH-1:0] prod   [CORE];
   logic signed [ACCW-1:0]     macSum [CORE];
   logic signed [DWIDTH-1:0]   conv   [CORE];
   logic signed [DWIDTH-1:0]   relu   [CORE];

   logic lastFx, lastFy, lastK, lastWx, lastWy, lastPx, lastPy, lastG, lastWc;
   logic lastMac, firstWin;

   logic                     imgWe;
   logic [IMGSIZE-1:0]       imgWAddr;
   logic signed [DWIDTH-1:0] imgWData;

   assign start = (state_q == IDLE) && host.req;

   // Address generation; all arithmetic wraps to the memory depth by truncation.
   always_comb begin
      iSq       = 32'(iSz_q) * 32'(iSz_q);
      fSq       = 32'(fSz_q) * 32'(fSz_q);
      blk       = 32'(nIn_q) * fSq + 32'd1;
      gBase     = 32'(netBase_q) + 32'(g_q) * blk;
      wAddr     = NETSIZE'(gBase + 32'(k_q) * fSq + 32'(fy_q) * 32'(fSz_q) + 32'(fx_q));
      bAddr     = NETSIZE'(gBase + 32'(nIn_q) * fSq);
      rowY      = 32'(py_q) * 32'(pSz_q) + 32'(wy_q) + 32'(fy_q);
      colX      = 32'(px_q) * 32'(pSz_q) + 32'(wx_q) + 32'(fx_q);
      pAddr     = IMGSIZE'(32'(inBase_q) + 32'(k_q) * iSq + rowY * 32'(iSz_q) + colX);
      chan      = 32'(g_q) * 32'(CORE) + 32'(wc_q);
      chanValid = chan < 32'(nOut_q);
      oAddr     = IMGSIZE'(32'(outBase_q) + chan * 32'(oSz_q) * 32'(oSz_q)
                           + 32'(py_q) * 32'(oSz_q) + 32'(px_q));
   end

   // Per-core MAC; on the last tap the shifted sum plus bias is truncated and rectified.
   always_comb begin
      pix = imgMem[pAddr];
      for (int c = 0; c < CORE; c++) begin
         wgt[c]    = netMem[c][wAddr];
         bias[c]   = netMem[c][bAddr];
         prod[c]   = wgt[c] * pix;
         macSum[c] = acc_q[c] + ACCW'(prod[c]);
         conv[c]   = DWIDTH'((macSum[c] >>> QBITS) + ACCW'(bias[c]));
         relu[c]   = conv[c][DWIDTH-1] ? '0 : conv[c];
      end
   end

   always_comb begin
      lastFx   = fx_q == fSz_q - ONE;
      lastFy   = fy_q == fSz_q - ONE;
      lastK    = k_q  == nIn_q - ONE;
      lastWx   = wx_q == pSz_q - ONE;
      lastWy   = wy_q == pSz_q - ONE;
      lastPx   = px_q == oSz_q - ONE;
      lastPy   = py_q == oSz_q - ONE;
      lastWc   = wc_q == CORELOG'(CORE - 1);
      lastG    = (32'(g_q) + 32'd1) * 32'(CORE) >= 32'(nOut_q);
      lastMac  = lastFx && lastFy && lastK;
      firstWin = (wx_q == '0) && (wy_q == '0);
   end

   // Next-state logic: nested loop counters fx, fy, k, window pixel, then core write-out, px, py, group.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      g_d  = g_q;  py_d = py_q; px_d = px_q; wy_d = wy_q;
      wx_d = wx_q; k_d  = k_q;  fy_d = fy_q; fx_d = fx_q;
      wc_d = wc_q;
      acc_d = acc_q;
      mx_d  = mx_q;
      case (state_q)
         IDLE: begin
            if (host.req) begin
               state_d = RUN;
               ack_d   = 1'b0;
               g_d  = '0; py_d = '0; px_d = '0; wy_d = '0;
               wx_d = '0; k_d  = '0; fy_d = '0; fx_d = '0;
               wc_d = '0;
               for (int c = 0; c < CORE; c++) acc_d[c] = '0;
            end
         end
         RUN: begin
            fx_d = fx_q + ONE;
            if (lastFx) begin
               fx_d = '0;
               fy_d = fy_q + ONE;
               if (lastFy) begin
                  fy_d = '0;
                  k_d  = k_q + ONE;
                  if (lastK) begin
                     k_d  = '0;
                     wx_d = wx_q + ONE;
                     if (lastWx) begin
                        wx_d = '0;
                        wy_d = wy_q + ONE;
                        if (lastWy) begin
                           wy_d    = '0;
                           wc_d    = '0;
                           state_d = WRITE;
                        end
                     end
                  end
               end
            end
            for (int c = 0; c < CORE; c++) begin
               acc_d[c] = lastMac ? '0 : macSum[c];
               if (lastMac && (firstWin || relu[c] > mx_q[c])) mx_d[c] = relu[c];
            end
         end
         WRITE: begin
            wc_d = wc_q + WONE;
            if (lastWc) begin
               wc_d = '0;
               px_d = px_q + ONE;
               state_d = RUN;
               if (lastPx) begin
                  px_d = '0;
                  py_d = py_q + ONE;
                  if (lastPy) begin
                     py_d = '0;
                     g_d  = g_q + ONE;
                     if (lastG) begin
                        g_d     = '0;
                        state_d = DONE;
                     end
                  end
               end
            end
         end
         DONE: begin
            ack_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         readImg_q <= '0;
         g_q  <= '0; py_q <= '0; px_q <= '0; wy_q <= '0;
         wx_q <= '0; k_q  <= '0; fy_q <= '0; fx_q <= '0;
         wc_q <= '0;
         inBase_q <= '0; outBase_q <= '0; netBase_q <= '0;
         nOut_q <= '0; nIn_q <= '0; iSz_q <= '0; fSz_q <= '0; pSz_q <= '0; oSz_q <= '0;
         for (int c = 0; c < CORE; c++) begin
            acc_q[c] <= '0;
            mx_q[c]  <= '0;
         end
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         g_q  <= g_d;  py_q <= py_d; px_q <= px_d; wy_q <= wy_d;
         wx_q <= wx_d; k_q  <= k_d;  fy_q <= fy_d; fx_q <= fx_d;
         wc_q <= wc_d;
         acc_q <= acc_d;
         mx_q  <= mx_d;
         if (state_q == IDLE) readImg_q <= imgMem[host.input_addr];
         if (start) begin
            inBase_q  <= host.input_addr;
            outBase_q <= host.output_addr;
            netBase_q <= host.net_addr;
            nOut_q    <= host.total_out;
            nIn_q     <= host.total_in;
            iSz_q     <= host.img_size;
            fSz_q     <= host.fil_size;
            pSz_q     <= host.pool_size;
            oSz_q     <= (host.img_size - host.fil_size + ONE) / host.pool_size;
         end
      end
   end

   // Image memory has one write port shared by host loads (idle only) and pooled write-back.
   always_comb begin
      imgWe    = 1'b0;
      imgWAddr = host.input_addr;
      imgWData = host.write_img;
      if (!xrst) begin
         if (state_q == IDLE && host.img_we) begin
            imgWe = 1'b1;
         end else if (state_q == WRITE && chanValid) begin
            imgWe    = 1'b1;
            imgWAddr = oAddr;
            imgWData = mx_q[wc_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (imgWe) imgMem[imgWAddr] <= imgWData;
      for (int c = 0; c < CORE; c++) begin
         if (!xrst && state_q == IDLE && host.net_we == NWW'(c + 1))
            netMem[c][host.net_addr] <= host.write_net;
      end
   end

   assign host.ack      = ack_q;
   assign host.read_img = readImg_q;
endmodule

// File: tb/tb_renkon.sv
// Self-checking bench for renkon: loads memories, runs layers, and reads results back against
// a behavioural conv/bias/ReLU/pool model through an address/data scoreboard.
module tb_renkon;
   localparam int CORE    = 8;
   localparam int DWIDTH  = 16;
   localparam int IMGSIZE = 12;
   localparam int NETSIZE = 14;
   localparam int LWIDTH  = 10;

   logic clk = 1'b0;
   logic xrst;

   renkon_if #(.CORE(CORE), .DWIDTH(DWIDTH), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE), .LWIDTH(LWIDTH)) hostIf ();

   renkon dut (.clk(clk), .xrst(xrst), .host(hostIf.slave));

   always #5 clk = ~clk;

   typedef struct {int addr; int data;} expEntry_t;
   expEntry_t expQ[$];

   int modelImg [2**IMGSIZE];
   int modelNet [CORE][2**NETSIZE];
   int passCount  = 0;
   int checkCount = 0;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
   endtask

   task automatic writeImg(input int addr, input int data);
      @(negedge clk);
      hostIf.input_addr = IMGSIZE'(addr);
      hostIf.write_img  = DWIDTH'(data);
      hostIf.img_we     = 1'b1;
      @(negedge clk);
      hostIf.img_we     = 1'b0;
      modelImg[addr]    = data;
   endtask

   task automatic writeNet(input int core, input int addr, input int data);
      @(negedge clk);
      hostIf.net_addr  = NETSIZE'(addr);
      hostIf.write_net = DWIDTH'(data);
      hostIf.net_we    = 4'(core + 1);
      @(negedge clk);
      hostIf.net_we    = '0;
      modelNet[core][addr] = data;
   endtask

   task automatic applyStimulus(input int nOut, input int nIn, input int iSz, input int fSz,
                                input int pSz, input int inBase, input int outBase, input int netBase);
      @(negedge clk);
      hostIf.total_out   = LWIDTH'(nOut);
      hostIf.total_in    = LWIDTH'(nIn);
      hostIf.img_size    = LWIDTH'(iSz);
      hostIf.fil_size    = LWIDTH'(fSz);
      hostIf.pool_size   = LWIDTH'(pSz);
      hostIf.input_addr  = IMGSIZE'(inBase);
      hostIf.output_addr = IMGSIZE'(outBase);
      hostIf.net_addr    = NETSIZE'(netBase);
      hostIf.req         = 1'b1;
      @(negedge clk);
      hostIf.req         = 1'b0;
   endtask

   task automatic waitAck(input string tag, input int budget);
      int n = 0;
      while (!hostIf.ack && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, int'(hostIf.ack), 1);
   endtask

   // Reference layer: pushes every word the accelerator should write, then updates the image model.
   task automatic computeModel(input int nOut, input int nIn, input int iSz, input int fSz,
                               input int pSz, input int inBase, input int outBase, input int netBase);
      int cSz, oSz, blk, c, g, mx, relu, addr;
      longint acc;
      shortint t;
      expEntry_t pend[$];
      cSz = iSz - fSz + 1;
      oSz = cSz / pSz;
      blk = nIn*fSz*fSz + 1;
      for (int n = 0; n < nOut; n++) begin
         c = n % CORE;
         g = n / CORE;
         for (int py = 0; py < oSz; py++)
            for (int px = 0; px < oSz; px++) begin
               mx = 0;
               for (int wy = 0; wy < pSz; wy++)
                  for (int wx = 0; wx < pSz; wx++) begin
                     acc = 0;
                     for (int k = 0; k < nIn; k++)
                        for (int fy = 0; fy < fSz; fy++)
                           for (int fx = 0; fx < fSz; fx++)
                              acc += longint'(modelImg[(inBase + k*iSz*iSz + (py*pSz+wy+fy)*iSz
                                                        + px*pSz+wx+fx) % 4096])
                                     * longint'(modelNet[c][(netBase + g*blk + k*fSz*fSz
                                                             + fy*fSz + fx) % 16384]);
                     acc  = (acc >>> 8) + longint'(modelNet[c][(netBase + g*blk + nIn*fSz*fSz) % 16384]);
                     t    = shortint'(acc);
                     relu = (t < 0) ? 0 : int'(t);
                     if (relu > mx) mx = relu;
                  end
               addr = (outBase + n*oSz*oSz + py*oSz + px) % 4096;
               pend.push_back('{addr, mx});
            end
      end
      foreach (pend[i]) begin
         expQ.push_back(pend[i]);
         modelImg[pend[i].addr] = pend[i].data;
      end
   endtask

   task automatic readBack(input string tag);
      expEntry_t e;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         @(negedge clk);
         hostIf.input_addr = IMGSIZE'(e.addr);
         @(negedge clk);
         checkOutput($sformatf("%s[%0d]", tag, e.addr), int'(hostIf.read_img), e.data);
      end
   endtask

   initial begin
      hostIf.req = 1'b0; hostIf.img_we = 1'b0; hostIf.net_we = '0;
      hostIf.input_addr = '0; hostIf.output_addr = '0; hostIf.write_img = '0;
      hostIf.net_addr = '0; hostIf.write_net = '0;
      hostIf.total_out = '0; hostIf.total_in = '0; hostIf.img_size = '0;
      hostIf.fil_size = '0; hostIf.pool_size = '0;
      xrst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("resetAck", int'(hostIf.ack), 0);
      checkOutput("resetReadImg", int'(hostIf.read_img), 0);
      xrst = 1'b0;

      writeImg(5, 37);
      expQ.push_back('{5, 37});
      readBack("hostRW");

      $display("[TB] identity layer");
      for (int i = 0; i < 16; i++) writeImg(i, i);
      writeNet(0, 0, 256);
      writeNet(0, 1, 0);
      applyStimulus(1, 1, 4, 1, 1, 0, 1024, 0);
      waitAck("identityAck", 2000);
      for (int i = 0; i < 16; i++) expQ.push_back('{1024 + i, i});
      readBack("identity");

      $display("[TB] bias and relu");
      for (int i = 0; i < 16; i++) writeImg(i, -3);
      writeNet(0, 1, 5);
      applyStimulus(1, 1, 4, 1, 1, 0, 1024, 0);
      waitAck("bias5Ack", 2000);
      for (int i = 0; i < 16; i++) expQ.push_back('{1024 + i, 2});
      readBack("bias5");
      writeNet(0, 1, 1);
      applyStimulus(1, 1, 4, 1, 1, 0, 1024, 0);
      waitAck("bias1Ack", 2000);
      for (int i = 0; i < 16; i++) expQ.push_back('{1024 + i, 0});
      readBack("bias1Relu");

      $display("[TB] max pool");
      for (int i = 0; i < 16; i++) writeImg(i, i);
      writeNet(0, 1, 0);
      applyStimulus(1, 1, 4, 1, 2, 0, 1100, 0);
      waitAck("poolAck", 2000);
      expQ.push_back('{1100, 5});
      expQ.push_back('{1101, 7});
      expQ.push_back('{1102, 13});
      expQ.push_back('{1103, 15});
      readBack("pool");

      $display("[TB] multi-core partial group and handshake");
      for (int i = 0; i < 2*12*12; i++) writeImg(i, int'($urandom_range(0, 1023)) - 512);
      for (int c = 0; c < CORE; c++)
         for (int a = 100; a < 100 + 2*51; a++)
            writeNet(c, a, int'($urandom_range(0, 600)) - 300);
      for (int c = 0; c < CORE; c++) begin
         writeNet(c, 100 + 50, int'($urandom_range(0, 2000)) - 1000);
         writeNet(c, 100 + 101, int'($urandom_range(0, 2000)) - 1000);
      end
      writeImg(2048 + 160, 12345);
      writeImg(2500, 222);
      writeImg(3000, 111);
      applyStimulus(10, 2, 12, 5, 2, 0, 2048, 100);
      checkOutput("ackClearedOnStart", int'(hostIf.ack), 0);
      repeat (10) @(negedge clk);
      hostIf.input_addr  = IMGSIZE'(3000);
      hostIf.write_img   = DWIDTH'(999);
      hostIf.img_we      = 1'b1;
      hostIf.output_addr = IMGSIZE'(2500);
      hostIf.req         = 1'b1;
      @(negedge clk);
      hostIf.img_we      = 1'b0;
      hostIf.req         = 1'b0;
      hostIf.output_addr = IMGSIZE'(2048);
      repeat (5) @(negedge clk);
      checkOutput("ackLowDuringRun", int'(hostIf.ack), 0);
      waitAck("multiAck", 20000);
      computeModel(10, 2, 12, 5, 2, 0, 2048, 100);
      expQ.push_back('{2048 + 160, 12345});
      expQ.push_back('{2500, 222});
      expQ.push_back('{3000, 111});
      readBack("multi");
      checkOutput("ackHolds", int'(hostIf.ack), 1);

      applyStimulus(10, 2, 12, 5, 2, 0, 2048, 100);
      checkOutput("ackClearedSecondReq", int'(hostIf.ack), 0);
      waitAck("repeatAck", 20000);
      computeModel(10, 2, 12, 5, 2, 0, 2048, 100);
      readBack("repeat");

      $display("[TB] abort by reset");
      applyStimulus(10, 2, 12, 5, 2, 0, 2048, 100);
      repeat (30) @(negedge clk);
      xrst = 1'b1;
      @(negedge clk);
      xrst = 1'b0;
      checkOutput("abortAck", int'(hostIf.ack), 0);
      repeat (50) @(negedge clk);
      checkOutput("abortStaysIdle", int'(hostIf.ack), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
